// File: rtl/history_store.sv
// Per-pixel 4-bit history store: a raster-scanned read port with one-cycle latency,
// a write-back port with write-first bypass, and a self-clearing sweep after reset or clear.
module history_store #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int DEPTH    = H_ACTIVE * V_ACTIVE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        VGA_VS,
   input  logic        pixel_en,
   input  logic        clear,
   input  logic        we,
   input  logic [18:0] write_addr,
   input  logic [3:0]  updated_color_history,
   output logic [18:0] read_addr,
   output logic [9:0]  read_x,
   output logic [9:0]  read_y,
   output logic [3:0]  color_history,
   output logic        color_valid,
   output logic        busy
);

   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [9:0]  X_LAST   = 10'(H_ACTIVE - 1);
   localparam logic [9:0]  Y_LAST   = 10'(V_ACTIVE - 1);
   localparam logic [18:0] CLR_LAST = 19'(DEPTH - 1);
   localparam logic [19:0] DEPTH_W  = 20'(DEPTH);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   logic [3:0] mem [0:DEPTH-1];

   state_t      state_reg, state_next;
   logic [18:0] clr_ptr_reg, clr_ptr_next;
   logic [9:0]  scan_x_reg, scan_x_next;
   logic [9:0]  scan_y_reg, scan_y_next;
   logic [18:0] scan_addr_reg, scan_addr_next;
   logic        vs_reg;

   logic [18:0] read_addr_reg;
   logic [9:0]  read_x_reg, read_y_reg;
   logic [3:0]  rd_data_reg;
   logic        color_valid_reg;

   logic          vs_fall;
   logic          rd_accept;
   logic          wr_accept;
   logic          bypass;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [3:0]    mem_wdata;

   assign vs_fall   = vs_reg & ~VGA_VS;
   assign rd_accept = (state_reg == ST_RUN) && pixel_en && !vs_fall;
   assign wr_accept = (state_reg == ST_RUN) && we && !clear
                      && ({1'b0, write_addr} < DEPTH_W);
   assign bypass    = wr_accept && (write_addr == scan_addr_reg);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_CLEAR;
         clr_ptr_reg   <= '0;
         scan_x_reg    <= '0;
         scan_y_reg    <= '0;
         scan_addr_reg <= '0;
      end else begin
         state_reg     <= state_next;
         clr_ptr_reg   <= clr_ptr_next;
         scan_x_reg    <= scan_x_next;
         scan_y_reg    <= scan_y_next;
         scan_addr_reg <= scan_addr_next;
      end
   end

   // The edge register keeps tracking VS through reset so no false edge follows it.
   always_ff @(posedge clk) begin
      vs_reg <= VGA_VS;
   end

   // Next-state logic
   always_comb begin
      state_next   = state_reg;
      clr_ptr_next = clr_ptr_reg;
      case (state_reg)
         ST_CLEAR: begin
            if (clr_ptr_reg == CLR_LAST) begin
               state_next   = ST_RUN;
               clr_ptr_next = '0;
            end else begin
               clr_ptr_next = clr_ptr_reg + 19'd1;
            end
         end
         ST_RUN: begin
            if (clear) begin
               state_next   = ST_CLEAR;
               clr_ptr_next = '0;
            end
         end
         default: begin
            state_next   = ST_CLEAR;
            clr_ptr_next = '0;
         end
      endcase
   end

   // Raster counters; the linear address steps by one, so no multiply is needed.
   always_comb begin
      scan_x_next    = scan_x_reg;
      scan_y_next    = scan_y_reg;
      scan_addr_next = scan_addr_reg;
      if (state_reg != ST_RUN || clear || vs_fall) begin
         scan_x_next    = '0;
         scan_y_next    = '0;
         scan_addr_next = '0;
      end else if (pixel_en) begin
         if (scan_x_reg == X_LAST) begin
            scan_x_next = '0;
            if (scan_y_reg == Y_LAST) begin
               scan_y_next    = '0;
               scan_addr_next = '0;
            end else begin
               scan_y_next    = scan_y_reg + 10'd1;
               scan_addr_next = scan_addr_reg + 19'd1;
            end
         end else begin
            scan_x_next    = scan_x_reg + 10'd1;
            scan_addr_next = scan_addr_reg + 19'd1;
         end
      end
   end

   // Output logic: the single write port is shared by the clear sweep and write-back.
   always_comb begin
      busy      = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = write_addr[AW-1:0];
      mem_wdata = updated_color_history;
      if (state_reg == ST_CLEAR) begin
         busy      = 1'b1;
         mem_we    = 1'b1;
         mem_waddr = clr_ptr_reg[AW-1:0];
         mem_wdata = 4'd0;
      end else begin
         mem_we = wr_accept;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_reg     <= '0;
         read_addr_reg   <= '0;
         read_x_reg      <= '0;
         read_y_reg      <= '0;
         color_valid_reg <= 1'b0;
      end else begin
         color_valid_reg <= rd_accept;
         if (rd_accept) begin
            rd_data_reg   <= bypass ? updated_color_history : mem[scan_addr_reg[AW-1:0]];
            read_addr_reg <= scan_addr_reg;
            read_x_reg    <= scan_x_reg;
            read_y_reg    <= scan_y_reg;
         end
      end
   end

   assign read_addr     = read_addr_reg;
   assign read_x        = read_x_reg;
   assign read_y        = read_y_reg;
   assign color_history = rd_data_reg;
   assign color_valid   = color_valid_reg;

endmodule

// File: tb/tb_history_store.sv
// Directed bench for history_store on a reduced 16x8 raster (DEPTH 128).
module tb_history_store;

   localparam int H = 16;
   localparam int V = 8;
   localparam int D = H * V;

   logic        clk = 1'b0;
   logic        reset, VGA_VS, pixel_en, clear, we;
   logic [18:0] write_addr;
   logic [3:0]  updated_color_history;
   logic [18:0] read_addr;
   logic [9:0]  read_x, read_y;
   logic [3:0]  color_history;
   logic        color_valid, busy;

   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] exp_mem [0:D-1];

   history_store #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .clk(clk), .reset(reset), .VGA_VS(VGA_VS), .pixel_en(pixel_en),
      .clear(clear), .we(we), .write_addr(write_addr),
      .updated_color_history(updated_color_history),
      .read_addr(read_addr), .read_x(read_x), .read_y(read_y),
      .color_history(color_history), .color_valid(color_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count busy cycles starting from the current sample; pixel_en/we are left as driven.
   task automatic wait_sweep(input string tag);
      int n = 0;
      int bad = 0;
      while (busy && n < 1000) begin
         n++;
         tick();
         if (color_valid) bad++;
      end
      check({tag, "_len"}, n, D);
      check({tag, "_valid"}, bad, 0);
      $display("sweep %s: %0d busy cycles", tag, n);
   endtask

   task automatic pix_read(input int addr);
      pixel_en = 1'b1;
      tick();
      pixel_en = 1'b0;
      check("rd_valid", color_valid, 1);
      check("rd_addr", read_addr, addr);
      check("rd_x", read_x, addr % H);
      check("rd_y", read_y, addr / H);
      check("rd_data", color_history, exp_mem[addr]);
      $display("read addr=%0d x=%0d y=%0d data=%h", read_addr, read_x, read_y, color_history);
   endtask

   task automatic vs_frame();
      VGA_VS = 1'b1;
      tick();
      VGA_VS = 1'b0;
      tick();
   endtask

   task automatic write_back(input int addr, input logic [3:0] data);
      we = 1'b1;
      write_addr = 19'(addr);
      updated_color_history = data;
      tick();
      we = 1'b0;
      if (addr < D) exp_mem[addr] = data;
      $display("write addr=%0d data=%h", addr, data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < D; i++) exp_mem[i] = 4'd0;
      reset = 1'b1; VGA_VS = 1'b1; pixel_en = 1'b0; clear = 1'b0; we = 1'b0;
      write_addr = '0; updated_color_history = '0;

      // Reset state
      tick();
      check("rst_busy", busy, 1);
      check("rst_valid", color_valid, 0);
      check("rst_addr", read_addr, 0);
      check("rst_data", color_history, 0);
      reset = 1'b0;
      VGA_VS = 1'b0;
      wait_sweep("reset");

      // Full frame of reads: line wrap and frame wrap
      for (int i = 0; i < D; i++) pix_read(i);
      pix_read(0);
      tick();
      check("idle_valid", color_valid, 0);
      check("idle_hold_addr", read_addr, 0);

      // Write-back, including an out-of-range address that would alias to 0
      vs_frame();
      write_back(5, 4'b1011);
      write_back(D, 4'b1111);
      vs_frame();
      for (int i = 0; i <= 10; i++) pix_read(i);

      // VS falls mid-line together with pixel_en
      VGA_VS = 1'b1;
      tick();
      VGA_VS = 1'b0;
      pixel_en = 1'b1;
      tick();
      pixel_en = 1'b0;
      check("vs_drop_valid", color_valid, 0);
      pix_read(0);

      // Collision at address 12 returns the write data
      for (int i = 1; i <= 11; i++) pix_read(i);
      pixel_en = 1'b1; we = 1'b1; write_addr = 19'd12; updated_color_history = 4'b0110;
      tick();
      pixel_en = 1'b0; we = 1'b0;
      exp_mem[12] = 4'b0110;
      check("coll_valid", color_valid, 1);
      check("coll_addr", read_addr, 12);
      check("coll_data", color_history, 4'b0110);

      // Clear request: same-cycle read completes, same-cycle and in-sweep writes are ignored
      write_back(3, 4'b1001);
      clear = 1'b1; pixel_en = 1'b1; we = 1'b1; write_addr = 19'd7; updated_color_history = 4'b1111;
      tick();
      clear = 1'b0; write_addr = 19'd20;
      check("clr_rd_valid", color_valid, 1);
      check("clr_rd_addr", read_addr, 13);
      check("clr_rd_data", color_history, 0);
      check("clr_busy", busy, 1);
      wait_sweep("clear");
      pixel_en = 1'b0; we = 1'b0;
      for (int i = 0; i < D; i++) exp_mem[i] = 4'd0;
      for (int i = 0; i <= 20; i++) pix_read(i);

      // Reset from RUN restores output reset values
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst2_addr", read_addr, 0);
      check("rst2_x", read_x, 0);
      check("rst2_y", read_y, 0);
      check("rst2_busy", busy, 1);
      wait_sweep("reset2");

      // Reset mid-sweep restarts it from address 0
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 50; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wait_sweep("midsweep");
      pix_read(0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
